mul_unit: RTL and testbench

Iterative multi-cycle multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It is the responder side of the controller's `mulstart`/`mulctl` → `exdone` handshake. It sits in the datapath's execute stage beside the ALU, takes rs1/rs2 operands, and returns a registered 32-bit result after a fixed latency. The fixed latency keeps controller sequencing and verification deterministic.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/mul_unit.sv | 117 +++++++++++
 tb/tb_mul_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execute-stage units.
// Holds the M-extension multiply selectors and the multiplier state encoding.
package riscv_pkg;

    localparam logic [1:0] MUL_LO  = 2'b00;
    localparam logic [1:0] MUL_HSS = 2'b01;
    localparam logic [1:0] MUL_HSU = 2'b10;
    localparam logic [1:0] MUL_HUU = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } mul_state_t;

endpackage

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Fixed XLEN+2 cycle latency from accept to the exdone pulse.
module mul_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            mulstart,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] result,
    output logic            exdone,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    mul_state_t          state_q;
    logic [1:0]          ctl_q;
    logic [XLEN-1:0]     mcand_q;
    logic [XLEN-1:0]     mplr_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     result_q;
    logic                exdone_q;

    logic                sign_a;
    logic                sign_b;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [XLEN:0]       add_w;
    logic [2*XLEN-1:0]   acc_d;
    logic [2*XLEN-1:0]   product;
    logic [XLEN-1:0]     result_d;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (mulctl)
            MUL_HSS: begin
                sign_a = opa[XLEN-1];
                sign_b = opb[XLEN-1];
            end
            MUL_HSU: sign_a = opa[XLEN-1];
            MUL_LO, MUL_HUU: ;
            default: ;
        endcase
        mag_a = sign_a ? -opa : opa;
        mag_b = sign_b ? -opb : opb;

        // Carry out of the upper-half add is shifted back in as the new MSB.
        add_w = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        if (mplr_q[0]) begin
            acc_d = {add_w, acc_q[XLEN-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end

        product  = neg_q ? -acc_q : acc_q;
        result_d = (ctl_q == MUL_LO) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // NOTE: the whole datapath is reset so an aborted operation leaves no stale state behind.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ctl_q    <= MUL_LO;
            mcand_q  <= '0;
            mplr_q   <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exdone_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
            exdone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mulstart) begin
                        ctl_q   <= mulctl;
                        mcand_q <= mag_a;
                        mplr_q  <= mag_b;
                        neg_q   <= sign_a ^ sign_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_q >> 1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    result_q <= result_d;
                    exdone_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign exdone = exdone_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed RV32M corner cases plus random
// operations against a 64-bit arithmetic reference, with latency/handshake checks.
module tb_mul_unit;

    logic        clk;
    logic        rstn;
    logic        mulstart;
    logic [1:0]  mulctl;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] result;
    logic        exdone;
    logic        busy;

    int n_checks;
    int n_fail;

    mul_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mulstart (mulstart),
        .mulctl   (mulctl),
        .opa      (opa),
        .opb      (opb),
        .result   (result),
        .exdone   (exdone),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: sign/zero extend to 64 bits and multiply.
    function automatic logic [31:0] ref_mul(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic        [63:0] p;
        ea = (ctl == 2'b01 || ctl == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (ctl == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (ctl == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Starts an op at the current time (between edges), runs to exdone, checks
    // latency, busy length and result. Returns in the exdone cycle, #1 after edge.
    task automatic do_op(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
        int edges;
        int busy_cnt;
        int early_done;
        logic [31:0] exp;
        exp      = ref_mul(ctl, a, b);
        mulstart = 1'b1;
        mulctl   = ctl;
        opa      = a;
        opb      = b;
        @(posedge clk);
        #1;
        mulstart   = 1'b0;
        opa        = $urandom;
        opb        = $urandom;
        mulctl     = 2'($urandom_range(0, 3));
        edges      = 1;
        busy_cnt   = busy ? 1 : 0;
        early_done = 0;
        while (!exdone && edges < 100) begin
            mulstart = (poke && edges == 9);
            if (poke && edges == 9) begin
                opa    = 32'h1234_5678;
                opb    = 32'h0000_0003;
                mulctl = 2'b00;
            end
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cnt++;
        end
        mulstart = 1'b0;
        check({tag, " latency"}, 32'(edges), 32'd34);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
        check({tag, " result"}, result, exp);
    endtask

    task automatic tail_check(input string tag, input int cycles);
        logic [31:0] held;
        int extra;
        held  = result;
        extra = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (exdone) extra++;
        end
        check({tag, " no_extra_exdone"}, 32'(extra), 32'd0);
        check({tag, " result_held"}, result, held);
    endtask

    initial begin
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        mulstart = 1'b0;
        mulctl   = 2'b00;
        opa      = '0;
        opb      = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 32'h0);
        check("reset exdone", 32'(exdone), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        do_op("mul 7x6", 2'b00, 32'd7, 32'd6, 1'b0);
        tail_check("mul 7x6", 1);
        do_op("mulh min*min", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mulh min*min const", result, 32'h4000_0000);
        tail_check("mulh min*min", 1);
        do_op("mulh -1*5", 2'b01, 32'hFFFF_FFFF, 32'd5, 1'b0);
        check("mulh -1*5 const", result, 32'hFFFF_FFFF);
        do_op("mulhsu -1*max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mulhsu const", result, 32'hFFFF_FFFF);
        do_op("mulhu max*max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mulhu const", result, 32'hFFFF_FFFE);
        do_op("mul max*max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mul const", result, 32'h0000_0001);
        tail_check("mul max*max", 1);

        // Request while busy must be ignored.
        do_op("poke", 2'b01, 32'hDEAD_BEEF, 32'h8765_4321, 1'b1);
        tail_check("poke", 45);

        // Back-to-back: each op starts in the previous op's exdone cycle.
        for (int i = 0; i < 24; i++) begin
            c = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (i % 6 == 1) a = 32'h8000_0000;
            if (i % 6 == 2) b = 32'h0;
            if (i % 6 == 3) b = 32'hFFFF_FFFF;
            do_op($sformatf("rand%0d ctl%0d", i, c), c, a, b, 1'b0);
        end
        tail_check("rand end", 3);

        // Asynchronous reset mid-operation.
        do_op("pre-reset", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        mulstart = 1'b1;
        mulctl   = 2'b00;
        opa      = 32'd11;
        opb      = 32'd13;
        @(posedge clk);
        #1;
        mulstart = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset exdone", 32'(exdone), 32'd0);
        check("midreset result", result, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tail_check("after reset", 40);
        do_op("post-reset", 2'b10, 32'hFFFF_FFF0, 32'd100, 1'b0);
        tail_check("post-reset", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
